bcd_updown_counter: RTL and testbench



---
 rtl/bcd_updown_counter.sv | 155 +++++++++++++++
 tb/tb_bcd_updown_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Up/down decimal counter with start/stop/load control, tick-gated stepping, a programmable
// modulus, and binary, packed-BCD and optional 7-segment outputs (7-segment built with `UPDOWN_SEG_EN).
module bcd_updown_counter #(
   parameter  int DIGITS    = 2,
   parameter  int MAX_COUNT = 99,
   localparam int CW        = $clog2(MAX_COUNT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  up_down,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  load,
   input  logic [CW-1:0]         load_val,
   input  logic                  tick,
   output logic [CW-1:0]         count,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic [1:0]            state,
   output logic                  wrap
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      RUN_UP   = 2'b01,
      RUN_DOWN = 2'b10,
      HOLD     = 2'b11
   } state_t;

   localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  wrap_q, wrap_d;

   function automatic logic [CW-1:0] clip(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      r = (v > MAX_C) ? MAX_C : v;
      return r;
   endfunction

   function automatic logic [4*DIGITS-1:0] to_bcd(input logic [CW-1:0] v);
      logic [4*DIGITS-1:0] r;
      int unsigned         rem;
      r   = '0;
      rem = 32'(v);
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   // Priority load > stop > start > tick; direction is fixed by which RUN state was entered.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         state_d = IDLE;
         count_d = clip(load_val);
      end else begin
         case (state_q)
            IDLE: begin
               if (!stop && start) state_d = up_down ? RUN_UP : RUN_DOWN;
            end
            RUN_UP: begin
               if (stop) begin
                  state_d = HOLD;
               end else if (tick) begin
                  wrap_d  = (count_q == MAX_C);
                  count_d = (count_q == MAX_C) ? '0 : count_q + CW'(1);
               end
            end
            RUN_DOWN: begin
               if (stop) begin
                  state_d = HOLD;
               end else if (tick) begin
                  wrap_d  = (count_q == '0);
                  count_d = (count_q == '0) ? MAX_C : count_q - CW'(1);
               end
            end
            HOLD: begin
               if (stop) begin
                  state_d = IDLE;
                  count_d = '0;
               end else if (start) begin
                  state_d = up_down ? RUN_UP : RUN_DOWN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      bcd_d = to_bcd(count_d);
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         bcd_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bcd_q   <= bcd_d;
         wrap_q  <= wrap_d;
      end
   end

   assign state = state_q;
   assign count = count_q;
   assign bcd   = bcd_q;
   assign wrap  = wrap_q;

`ifdef UPDOWN_SEG_EN
   logic [7*DIGITS-1:0] seg_q;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   function automatic logic [7*DIGITS-1:0] to_seg(input logic [4*DIGITS-1:0] b);
      logic [7*DIGITS-1:0] s;
      for (int i = 0; i < DIGITS; i++) s[7*i +: 7] = seg7(b[4*i +: 4]);
      return s;
   endfunction

   // Decoded from the next BCD value so seg stays coherent with count and bcd.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) seg_q <= {DIGITS{7'h3F}};
      else       seg_q <= to_seg(bcd_d);
   end

   assign seg = seg_q;
`else
   assign seg = '0;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a 2-digit/99 instance checked every cycle against an arithmetic
// model plus hand-computed points, and a 3-digit/999 instance for the wide wrap case.
module tb_bcd_updown_counter;

   localparam int MAXC = 99;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        up_down = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0, tick = 1'b0;
   logic [6:0]  load_val = '0;
   logic [6:0]  count;
   logic [7:0]  bcd;
   logic [13:0] seg;
   logic [1:0]  state;
   logic        wrap;

   logic        up3 = 1'b0, start3 = 1'b0, stop3 = 1'b0, load3 = 1'b0, tick3 = 1'b0;
   logic [9:0]  lv3 = '0;
   logic [9:0]  count3;
   logic [11:0] bcd3;
   logic [20:0] seg3;
   logic [1:0]  state3;
   logic        wrap3;

   int checks = 0;
   int errors = 0;

   int m_state = 0;
   int m_count = 0;
   int m_wrap  = 0;
   int segtab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   bcd_updown_counter #(.DIGITS(2), .MAX_COUNT(99)) dut (
      .clk(clk), .rst_n(rst_n), .up_down(up_down), .start(start), .stop(stop),
      .load(load), .load_val(load_val), .tick(tick), .count(count), .bcd(bcd),
      .seg(seg), .state(state), .wrap(wrap)
   );

   bcd_updown_counter #(.DIGITS(3), .MAX_COUNT(999)) dut3 (
      .clk(clk), .rst_n(rst_n), .up_down(up3), .start(start3), .stop(stop3),
      .load(load3), .load_val(lv3), .tick(tick3), .count(count3), .bcd(bcd3),
      .seg(seg3), .state(state3), .wrap(wrap3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int segx(input int v);
`ifdef UPDOWN_SEG_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   function automatic int m_bcd(input int v);
      return (v / 10) * 16 + (v % 10);
   endfunction

   function automatic int m_seg(input int v);
      return segx((segtab[(v / 10) % 10] << 7) | segtab[v % 10]);
   endfunction

   // Reference: state numbers are the output encoding (0 idle, 1 up, 2 down, 3 hold).
   always @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         m_state = 0;
         m_count = 0;
         m_wrap  = 0;
      end else begin
         m_wrap = 0;
         if (load) begin
            m_state = 0;
            m_count = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
         end else if (stop) begin
            if (m_state == 1 || m_state == 2) m_state = 3;
            else if (m_state == 3) begin
               m_state = 0;
               m_count = 0;
            end
         end else if (start && (m_state == 0 || m_state == 3)) begin
            m_state = up_down ? 1 : 2;
         end else if (tick && m_state == 1) begin
            m_wrap  = (m_count == MAXC) ? 1 : 0;
            m_count = (m_count + 1) % (MAXC + 1);
         end else if (tick && m_state == 2) begin
            m_wrap  = (m_count == 0) ? 1 : 0;
            m_count = (m_count + MAXC) % (MAXC + 1);
         end
      end
   end

   always @(negedge clk) begin
      chk("m_state", int'(state), m_state);
      chk("m_count", int'(count), m_count);
      chk("m_bcd",   int'(bcd),   m_bcd(m_count));
      chk("m_seg",   int'(seg),   m_seg(m_count));
      chk("m_wrap",  int'(wrap),  m_wrap);
   end

   task automatic cyc(input logic s, input logic p, input logic l, input int lv,
                      input logic t, input logic u);
      start    = s;
      stop     = p;
      load     = l;
      load_val = 7'(lv);
      tick     = t;
      up_down  = u;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; load = 1'b0; tick = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_seg",   int'(seg),   segx({7'h3F, 7'h3F}));
      rst_n = 1'b0;

      // Count up five ticks from reset.
      cyc(1, 0, 0, 0, 0, 1);
      repeat (5) cyc(0, 0, 0, 0, 1, 1);
      chk("up5_count", int'(count), 5);
      chk("up5_bcd",   int'(bcd),   'h05);
      chk("up5_seg",   int'(seg),   segx({7'h3F, 7'h6D}));
      chk("up5_state", int'(state), 1);

      // Wrap at the top.
      cyc(0, 0, 1, 98, 0, 1);
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      chk("top_count99", int'(count), 99);
      chk("top_bcd99",   int'(bcd),   'h99);
      cyc(0, 0, 0, 0, 1, 1);
      chk("top_count0", int'(count), 0);
      chk("top_wrap",   int'(wrap),  1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("top_wrap_gone", int'(wrap), 0);
      cyc(0, 0, 0, 0, 1, 1);
      chk("top_bcd01", int'(bcd), 'h01);

      // Double stop clears, then count down through zero; direction stays latched.
      cyc(0, 1, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1);
      chk("clr_count", int'(count), 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("dn_count99", int'(count), 99);
      chk("dn_wrap",    int'(wrap),  1);
      repeat (2) cyc(0, 0, 0, 0, 1, 1);
      chk("latched_dir", int'(count), 97);

      // Hold freezes, resume upward, double stop.
      cyc(0, 1, 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 1, 1);
      chk("hold_state", int'(state), 3);
      chk("hold_count", int'(count), 97);
      cyc(1, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      chk("resume_up", int'(count), 98);
      cyc(0, 1, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 1);
      chk("stop2_state", int'(state), 0);
      chk("stop2_count", int'(count), 0);

      // Load clipping, start+stop in IDLE, held start, load beats tick.
      cyc(0, 0, 1, 120, 0, 1);
      chk("clip_count", int'(count), 99);
      cyc(1, 1, 0, 0, 0, 1);
      chk("startstop_idle", int'(state), 0);
      cyc(1, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1, 0);
      chk("held_start_state", int'(state), 1);
      chk("held_start_count", int'(count), 0);
      cyc(0, 0, 1, 5, 1, 1);
      chk("load_tick_state", int'(state), 0);
      chk("load_tick_count", int'(count), 5);

      // Asynchronous reset in the middle of a run.
      cyc(1, 0, 0, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 1, 1);
      #2 rst_n = 1'b1;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_state", int'(state), 0);
      chk("arst_bcd",   int'(bcd),   0);
      chk("arst_wrap",  int'(wrap),  0);
      chk("arst_seg",   int'(seg),   segx({7'h3F, 7'h3F}));
      @(posedge clk);
      #1 rst_n = 1'b0;
      cyc(0, 0, 0, 0, 1, 1);
      chk("post_rst_no_step", int'(count), 0);

      // Three-digit instance wrapping at 999.
      load3 = 1'b1; lv3 = 10'd999;
      @(posedge clk); #1 load3 = 1'b0;
      chk("d3_count999", int'(count3), 999);
      chk("d3_bcd999",   int'(bcd3),   'h999);
      start3 = 1'b1; up3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      tick3 = 1'b1;
      @(posedge clk); #1 tick3 = 1'b0;
      chk("d3_count0", int'(count3), 0);
      chk("d3_bcd0",   int'(bcd3),   'h000);
      chk("d3_wrap",   int'(wrap3),  1);
      chk("d3_seg",    int'(seg3),   segx({7'h3F, 7'h3F, 7'h3F}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
